// File: rtl/mem_arbiter_nm.sv
// N-master arbiter onto one single-port synchronous RAM with 1-cycle read latency.
// Round-robin or fixed-priority selection, per-master grant mask, registered read return.
module mem_arbiter_nm #(
  parameter int unsigned NM        = 2,
  parameter int unsigned DW        = 32,
  parameter int unsigned AW        = 32,
  parameter int unsigned PRIO_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NM-1:0]        m_req,
  input  logic [NM-1:0]        m_we,
  input  logic [NM*DW/8-1:0]   m_wstrb,
  input  logic [NM*AW-1:0]     m_addr,
  input  logic [NM*DW-1:0]     m_wdata,
  input  logic [NM-1:0]        m_mask,
  output logic [NM-1:0]        m_gnt,
  output logic [NM-1:0]        m_rvalid,
  output logic [DW-1:0]        m_rdata,
  output logic                 s_ren,
  output logic [DW/8-1:0]      s_wen,
  output logic [AW-1:0]        s_addr,
  output logic [DW-1:0]        s_wdata,
  input  logic [DW-1:0]        s_rdata
);

  localparam int unsigned BW = DW / 8;
  localparam int unsigned PW = (NM > 1) ? $clog2(NM) : 1;

  logic [NM-1:0] eligible;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] gnt_idx;
  logic          gnt_vld;
  logic [PW-1:0] rd_owner;
  logic          rd_pend;

  assign eligible = m_req & ~m_mask;

  // Search eligible masters starting at rr_ptr (or at 0 in fixed-priority mode).
  always_comb begin : arb
    int unsigned idx;
    idx     = 0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int unsigned off = 0; off < NM; off++) begin
      if (PRIO_MODE == 1) begin
        idx = off;
      end else begin
        idx = 32'(rr_ptr) + off;
        if (idx >= NM) idx = idx - NM;
      end
      if (!gnt_vld && eligible[PW'(idx)]) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
  end

  always_comb begin : gnt_dec
    m_gnt = '0;
    if (gnt_vld) m_gnt[gnt_idx] = 1'b1;
  end

  // Granted master drives the RAM port in the same cycle; idle port is all zeros.
  always_comb begin : ram_mux
    s_ren   = 1'b0;
    s_wen   = '0;
    s_addr  = '0;
    s_wdata = '0;
    if (gnt_vld) begin
      s_ren   = ~m_we[gnt_idx];
      s_wen   = m_wstrb[32'(gnt_idx)*BW +: BW] & {BW{m_we[gnt_idx]}};
      s_addr  = m_addr[32'(gnt_idx)*AW +: AW];
      s_wdata = m_wdata[32'(gnt_idx)*DW +: DW];
    end
  end

  always_ff @(posedge clk or posedge rst) begin : seq
    if (rst) begin
      rr_ptr   <= '0;
      rd_pend  <= 1'b0;
      rd_owner <= '0;
    end else begin
      rd_pend <= s_ren;
      if (s_ren) rd_owner <= gnt_idx;
      if (PRIO_MODE == 0 && gnt_vld)
        rr_ptr <= (gnt_idx == PW'(NM - 1)) ? '0 : gnt_idx + PW'(1);
    end
  end

  // Return path: owner decode of the pending read, data straight from the RAM.
  always_comb begin : rsp
    m_rvalid = '0;
    if (rd_pend) m_rvalid[rd_owner] = 1'b1;
  end

  assign m_rdata = s_rdata;

endmodule

// File: tb/tb_mem_arbiter_nm.sv
// Directed bench: a 2-master round-robin arbiter with a small RAM model,
// plus a 3-master fixed-priority instance on the same clock and reset.
module tb_mem_arbiter_nm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Round-robin instance, NM=2
  logic [1:0]  r_req, r_we, r_mask, r_gnt, r_rvalid;
  logic [7:0]  r_wstrb;
  logic [63:0] r_addr, r_wdata;
  logic [31:0] r_rdata, r_s_wdata, r_s_rdata;
  logic [31:0] r_s_addr;
  logic [3:0]  r_s_wen;
  logic        r_s_ren;

  mem_arbiter_nm #(.NM(2), .DW(32), .AW(32), .PRIO_MODE(0)) u_rr (
    .clk(clk), .rst(rst),
    .m_req(r_req), .m_we(r_we), .m_wstrb(r_wstrb), .m_addr(r_addr),
    .m_wdata(r_wdata), .m_mask(r_mask), .m_gnt(r_gnt), .m_rvalid(r_rvalid),
    .m_rdata(r_rdata), .s_ren(r_s_ren), .s_wen(r_s_wen), .s_addr(r_s_addr),
    .s_wdata(r_s_wdata), .s_rdata(r_s_rdata)
  );

  // RAM model: 256 words, byte-write, 1-cycle read latency
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (r_s_ren) r_s_rdata <= mem[r_s_addr[9:2]];
    for (int b = 0; b < 4; b++)
      if (r_s_wen[b]) mem[r_s_addr[9:2]][8*b +: 8] <= r_s_wdata[8*b +: 8];
  end

  // Fixed-priority instance, NM=3
  logic [2:0]  f_req, f_we, f_mask, f_gnt, f_rvalid;
  logic [11:0] f_wstrb;
  logic [95:0] f_addr, f_wdata;
  logic [31:0] f_rdata, f_s_wdata, f_s_addr;
  logic [31:0] f_s_rdata = 32'h5A5A_5A5A;
  logic [3:0]  f_s_wen;
  logic        f_s_ren;

  mem_arbiter_nm #(.NM(3), .DW(32), .AW(32), .PRIO_MODE(1)) u_fp (
    .clk(clk), .rst(rst),
    .m_req(f_req), .m_we(f_we), .m_wstrb(f_wstrb), .m_addr(f_addr),
    .m_wdata(f_wdata), .m_mask(f_mask), .m_gnt(f_gnt), .m_rvalid(f_rvalid),
    .m_rdata(f_rdata), .s_ren(f_s_ren), .s_wen(f_s_wen), .s_addr(f_s_addr),
    .s_wdata(f_s_wdata), .s_rdata(f_s_rdata)
  );

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[64] = 32'hDEAD_BEEF;  // 0x100
    mem[4]  = 32'hCAFE_F00D;  // 0x10
    r_req = '0; r_we = '0; r_mask = '0; r_wstrb = '0; r_addr = '0; r_wdata = '0;
    f_req = '0; f_we = '0; f_mask = '0; f_wstrb = '0; f_wdata = '0;
    f_addr = {32'h300, 32'h200, 32'h100};

    repeat (2) @(negedge clk);
    #1;
    check("rst_gnt",    64'(r_gnt),    64'h0);
    check("rst_rvalid", 64'(r_rvalid), 64'h0);
    rst = 1'b0;
    #1;
    check("idle_ren",  64'(r_s_ren),  64'h0);
    check("idle_addr", 64'(r_s_addr), 64'h0);

    // RR contention: both read continuously, alternate from master0
    r_addr = {32'h10, 32'h100};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      r_req = 2'b11;
      #1;
      check($sformatf("rr_gnt%0d", c), 64'(r_gnt), (c % 2 == 0) ? 64'h1 : 64'h2);
      if (c > 0) begin
        check($sformatf("rr_rv%0d", c), 64'(r_rvalid), (c % 2 == 0) ? 64'h2 : 64'h1);
        check($sformatf("rr_rd%0d", c), 64'(r_rdata),
              (c % 2 == 0) ? 64'hCAFEF00D : 64'hDEADBEEF);
      end
    end
    @(negedge clk);
    r_req = 2'b00;
    #1;
    check("rr_rv_last", 64'(r_rvalid), 64'h2);
    check("rr_rd_last", 64'(r_rdata),  64'hCAFEF00D);

    // Single read by master0 at 0x100
    @(negedge clk);
    r_req = 2'b01;
    #1;
    check("sr_gnt",  64'(r_gnt),    64'h1);
    check("sr_ren",  64'(r_s_ren),  64'h1);
    check("sr_addr", 64'(r_s_addr), 64'h100);
    check("sr_wen",  64'(r_s_wen),  64'h0);
    @(negedge clk);
    r_req = 2'b00;
    #1;
    check("sr_rv", 64'(r_rvalid), 64'h1);
    check("sr_rd", 64'(r_rdata),  64'hDEADBEEF);
    check("sr_gnt_idle", 64'(r_gnt), 64'h0);

    // Mask: master0 blocked, rr_ptr at 1 then 0
    @(negedge clk);
    r_req = 2'b11; r_mask = 2'b01;
    #1;
    check("mk_gnt_a", 64'(r_gnt), 64'h2);
    @(negedge clk);
    #1;
    check("mk_gnt_b", 64'(r_gnt), 64'h2);
    @(negedge clk);
    r_mask = 2'b00;
    #1;
    check("mk_clear_gnt", 64'(r_gnt), 64'h1);
    // Masking after the read grant keeps its response
    @(negedge clk);
    r_req = 2'b00; r_mask = 2'b01;
    #1;
    check("mk_late_rv", 64'(r_rvalid), 64'h1);
    check("mk_late_rd", 64'(r_rdata),  64'hDEADBEEF);
    check("idle_addr2", 64'(r_s_addr), 64'h0);
    r_mask = 2'b00;

    // Byte write by master1 at 0x8, strobe 0100
    @(negedge clk);
    r_req = 2'b10; r_we = 2'b10; r_addr = {32'h8, 32'h8};
    r_wdata = {32'hAABB_CCDD, 32'h0}; r_wstrb = 8'b0100_0000;
    #1;
    check("bw_gnt",   64'(r_gnt),     64'h2);
    check("bw_wen",   64'(r_s_wen),   64'h4);
    check("bw_ren",   64'(r_s_ren),   64'h0);
    check("bw_addr",  64'(r_s_addr),  64'h8);
    check("bw_wdata", 64'(r_s_wdata), 64'hAABBCCDD);
    check("bw_rv",    64'(r_rvalid),  64'h0);
    @(negedge clk);
    r_req = 2'b01; r_we = 2'b00; r_wstrb = '0;
    #1;
    check("rb_gnt", 64'(r_gnt),    64'h1);
    check("wr_norsp", 64'(r_rvalid), 64'h0);
    @(negedge clk);
    r_req = 2'b00;
    #1;
    check("rb_rv", 64'(r_rvalid), 64'h1);
    check("rb_rd", 64'(r_rdata),  64'h00BB0000);

    // Zero-strobe write still granted, no RAM write
    @(negedge clk);
    r_req = 2'b01; r_we = 2'b01; r_wstrb = 8'h00;
    #1;
    check("z_gnt", 64'(r_gnt),   64'h1);
    check("z_wen", 64'(r_s_wen), 64'h0);
    check("z_ren", 64'(r_s_ren), 64'h0);

    // Reset in the cycle after a read grant
    @(negedge clk);
    r_we = 2'b00; r_addr = {32'h10, 32'h100};
    #1;
    check("mr_gnt", 64'(r_gnt), 64'h1);
    @(negedge clk);
    r_req = 2'b00; rst = 1'b1;
    #1;
    check("mr_rv", 64'(r_rvalid), 64'h0);
    @(negedge clk);
    rst = 1'b0; r_req = 2'b11;
    #1;
    check("mr_post_gnt", 64'(r_gnt), 64'h1);
    @(negedge clk);
    r_req = 2'b00;

    // Fixed priority NM=3: master1 wins over master2 until it drops
    f_req = 3'b110;
    #1;
    check("fp_gnt_a", 64'(f_gnt),    64'h2);
    check("fp_addr",  64'(f_s_addr), 64'h200);
    @(negedge clk);
    #1;
    check("fp_gnt_b", 64'(f_gnt),    64'h2);
    check("fp_rv_b",  64'(f_rvalid), 64'h2);
    @(negedge clk);
    f_req = 3'b100;
    #1;
    check("fp_gnt_c",  64'(f_gnt),    64'h4);
    check("fp_addr_c", 64'(f_s_addr), 64'h300);
    @(negedge clk);
    f_req = 3'b111;
    #1;
    check("fp_rv_c",  64'(f_rvalid), 64'h4);
    check("fp_rd_c",  64'(f_rdata),  64'h5A5A5A5A);
    check("fp_gnt_d", 64'(f_gnt),    64'h1);
    @(negedge clk);
    f_mask = 3'b001;
    #1;
    check("fp_gnt_m", 64'(f_gnt), 64'h2);
    @(negedge clk);
    f_req = 3'b000; f_mask = 3'b000;
    #1;
    check("fp_idle", 64'(f_gnt), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
